// File: rtl/mem_write_sequencer_pkg.sv
// Shared constants for the block-memory write sequencer: button indices and the
// default debounce interval.
package mem_write_sequencer_pkg;

  localparam int unsigned BTN_WR   = 0;
  localparam int unsigned BTN_STEP = 1;
  localparam int unsigned BTN_HOME = 2;
  localparam int unsigned BTN_CLR  = 3;
  localparam int unsigned BTN_NUM  = 5;

  // 10 ms at 100 MHz
  localparam int unsigned DEBOUNCE_CYC_DEFAULT = 1_000_000;

  // Counter width able to hold values 0..max_val
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted press.
module btn_debounce
  import mem_write_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYC);
  localparam logic [CntW-1:0] LastCnt = CntW'(DEBOUNCE_CYC - 1);

  logic [1:0]      sync_q;
  logic            level_q;
  logic            pulse_q;
  logic [CntW-1:0] cnt_q;

  // cnt_q counts consecutive synchronized samples that disagree with level_q;
  // the level flips on the DEBOUNCE_CYC-th such sample.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      pulse_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == LastCnt) begin
        cnt_q   <= '0;
        level_q <= sync_q[1];
        pulse_q <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/mem_write_sequencer.sv
// Turns debounced button presses into single port-A writes of SW at successive
// addresses and steps a port-B read pointer over the stored words.
module mem_write_sequencer
  import mem_write_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] SW,
  input  logic [4:0]        BTN,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              enb,
  output logic [ADDR_W-1:0] addrb,
  output logic [ADDR_W:0]   count,
  output logic              full
);

  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

  logic [3:0] btn_pulse;
  logic [3:0] btn_level;
  logic       unused_btn;

  assign unused_btn = BTN[4] ^ (^btn_level);

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn_debounce (
      .clk_i  (CLK),
      .rst_i  (RST),
      .btn_i  (BTN[i]),
      .level_o(btn_level[i]),
      .pulse_o(btn_pulse[i])
    );
  end

  logic wr_pulse, step_pulse, home_pulse, clr_pulse;
  assign wr_pulse   = btn_pulse[BTN_WR];
  assign step_pulse = btn_pulse[BTN_STEP];
  assign home_pulse = btn_pulse[BTN_HOME];
  assign clr_pulse  = btn_pulse[BTN_CLR];

  logic              ena_q, wea_q, enb_q, full_q;
  logic [ADDR_W-1:0] addra_q, addrb_q;
  logic [DATA_W-1:0] dina_q;
  logic [ADDR_W:0]   count_q;

  logic            wr_ok;
  logic [ADDR_W:0] addrb_inc;
  logic [ADDR_W:0] count_inc;

  assign wr_ok     = wr_pulse & ~clr_pulse & ~full_q;
  assign addrb_inc = {1'b0, addrb_q} + 1'b1;
  assign count_inc = count_q + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ena_q   <= 1'b0;
      wea_q   <= 1'b0;
      enb_q   <= 1'b0;
      full_q  <= 1'b0;
      addra_q <= '0;
      addrb_q <= '0;
      dina_q  <= '0;
      count_q <= '0;
    end else begin
      enb_q <= 1'b1;
      ena_q <= wr_ok;
      wea_q <= wr_ok;
      if (wr_ok) begin
        dina_q  <= SW;
        addra_q <= count_q[ADDR_W-1:0];
      end

      if (clr_pulse) begin
        count_q <= '0;
        full_q  <= 1'b0;
        addrb_q <= '0;
      end else begin
        if (wr_ok) begin
          count_q <= count_inc;
          full_q  <= (count_inc == DepthCnt);
        end
        // Step wrap compares against the count before this cycle's write lands.
        if (home_pulse) begin
          addrb_q <= '0;
        end else if (step_pulse) begin
          if (count_q == '0 || addrb_inc == count_q) begin
            addrb_q <= '0;
          end else begin
            addrb_q <= addrb_inc[ADDR_W-1:0];
          end
        end
      end
    end
  end

  assign ena   = ena_q;
  assign wea   = wea_q;
  assign enb   = enb_q;
  assign full  = full_q;
  assign addra = addra_q;
  assign addrb = addrb_q;
  assign dina  = dina_q;
  assign count = count_q;

endmodule
